alu_arbiter: RTL and testbench

//  Shares one combinational ALU (ctrl 010 add, 110 sub, 000 and, 001 or, 100 mul) between two requesters.

---
 rtl/alu_arbiter.sv | 116 +++++++++++
 tb/tb_alu_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Registers operands toward the ALU, holds it for the op latency, and returns a one-hot response pulse.
module alu_arbiter #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             r0_valid_i,
   output logic             r0_ready_o,
   input  logic [WIDTH-1:0] r0_data1_i,
   input  logic [WIDTH-1:0] r0_data2_i,
   input  logic [2:0]       r0_ctrl_i,
   input  logic             r1_valid_i,
   output logic             r1_ready_o,
   input  logic [WIDTH-1:0] r1_data1_i,
   input  logic [WIDTH-1:0] r1_data2_i,
   input  logic [2:0]       r1_ctrl_i,
   output logic [WIDTH-1:0] alu_data1_o,
   output logic [WIDTH-1:0] alu_data2_o,
   output logic [2:0]       alu_ctrl_o,
   input  logic [WIDTH-1:0] alu_data_i,
   input  logic             alu_zero_i,
   output logic [1:0]       rsp_valid_o,
   output logic [WIDTH-1:0] rsp_data_o,
   output logic             rsp_zero_o,
   output logic             busy_o,
   output logic             illegal_o
);

   localparam int CNT_W = $clog2(MUL_LAT) + 1;
   localparam logic [2:0] CTRL_ADD = 3'b010;
   localparam logic [2:0] CTRL_SUB = 3'b110;
   localparam logic [2:0] CTRL_AND = 3'b000;
   localparam logic [2:0] CTRL_OR  = 3'b001;
   localparam logic [2:0] CTRL_MUL = 3'b100;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             prio;
   logic             owner;

   logic             window;
   logic             accept;
   logic             grant_sel;
   logic [WIDTH-1:0] grant_data1;
   logic [WIDTH-1:0] grant_data2;
   logic [2:0]       grant_ctrl;
   logic             cur_illegal;

   function automatic logic ctrl_legal(input logic [2:0] ctrl);
      return (ctrl == CTRL_ADD) || (ctrl == CTRL_SUB) || (ctrl == CTRL_AND) ||
             (ctrl == CTRL_OR)  || (ctrl == CTRL_MUL);
   endfunction

   // Accepting in the final EXEC cycle lets single-cycle ops stream at full rate.
   assign window    = (state == IDLE) || (cnt == '0);
   assign accept    = window && (r0_valid_i || r1_valid_i);
   assign grant_sel = (r0_valid_i && r1_valid_i) ? prio : r1_valid_i;

   assign r0_ready_o = accept && !grant_sel;
   assign r1_ready_o = accept &&  grant_sel;

   assign grant_data1 = grant_sel ? r1_data1_i : r0_data1_i;
   assign grant_data2 = grant_sel ? r1_data2_i : r0_data2_i;
   assign grant_ctrl  = grant_sel ? r1_ctrl_i  : r0_ctrl_i;

   assign cur_illegal = !ctrl_legal(alu_ctrl_o);
   assign busy_o      = (state == EXEC);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         prio        <= 1'b0;
         owner       <= 1'b0;
         alu_data1_o <= '0;
         alu_data2_o <= '0;
         alu_ctrl_o  <= '0;
         rsp_valid_o <= 2'b00;
         rsp_data_o  <= '0;
         rsp_zero_o  <= 1'b0;
         illegal_o   <= 1'b0;
      end else begin
         // NOTE: pulses default low here and are overridden only on a capture edge;
         // later non-blocking assignments in the same block win.
         rsp_valid_o <= 2'b00;
         illegal_o   <= 1'b0;

         if (state == EXEC) begin
            if (cnt != '0) begin
               cnt <= cnt - CNT_W'(1);
            end else begin
               rsp_valid_o <= owner ? 2'b10 : 2'b01;
               rsp_data_o  <= cur_illegal ? '0   : alu_data_i;
               rsp_zero_o  <= cur_illegal ? 1'b1 : alu_zero_i;
               illegal_o   <= cur_illegal;
               state       <= IDLE;
            end
         end

         if (accept) begin
            alu_data1_o <= grant_data1;
            alu_data2_o <= grant_data2;
            alu_ctrl_o  <= grant_ctrl;
            cnt         <= (grant_ctrl == CTRL_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
            owner       <= grant_sel;
            prio        <= !grant_sel;
            state       <= EXEC;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter: a cycle-level reference model predicts grants,
// busy and ALU operands; a separate monitor pops expected responses as the DUT pulses them.
module tb_alu_arbiter;

   localparam int WIDTH   = 32;
   localparam int MUL_LAT = 3;

   typedef struct {
      logic [2:0]       ctrl;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } op_t;

   typedef struct {
      int               cyc;
      logic [1:0]       vld;
      logic [WIDTH-1:0] data;
      logic             zero;
      logic             ill;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             r0_valid, r0_ready, r1_valid, r1_ready;
   logic [WIDTH-1:0] r0_data1, r0_data2, r1_data1, r1_data2;
   logic [2:0]       r0_ctrl, r1_ctrl;
   logic [WIDTH-1:0] alu_data1, alu_data2, alu_data;
   logic [2:0]       alu_ctrl;
   logic             alu_zero;
   logic [1:0]       rsp_valid;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_zero;
   logic             busy;
   logic             illegal;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   op_t  reqq[2][$];
   op_t  cur[2];
   bit   pres[2];
   exp_t sb[$];

   int   prio_m;
   int   next_acc;
   int   busy_until;
   op_t  last_op;

   alu_arbiter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
      .clk_i(clk), .rst_i(rst),
      .r0_valid_i(r0_valid), .r0_ready_o(r0_ready),
      .r0_data1_i(r0_data1), .r0_data2_i(r0_data2), .r0_ctrl_i(r0_ctrl),
      .r1_valid_i(r1_valid), .r1_ready_o(r1_ready),
      .r1_data1_i(r1_data1), .r1_data2_i(r1_data2), .r1_ctrl_i(r1_ctrl),
      .alu_data1_o(alu_data1), .alu_data2_o(alu_data2), .alu_ctrl_o(alu_ctrl),
      .alu_data_i(alu_data), .alu_zero_i(alu_zero),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_zero_o(rsp_zero),
      .busy_o(busy), .illegal_o(illegal)
   );

   function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] c,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      case (c)
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b100:  return a * b;
         default: return 32'hdead_beef;
      endcase
   endfunction

   function automatic bit is_legal(input logic [2:0] c);
      return c inside {3'b010, 3'b110, 3'b000, 3'b001, 3'b100};
   endfunction

   // Stand-in for the shared ALU; illegal codes yield a nonzero garbage value.
   assign alu_data = alu_fn(alu_ctrl, alu_data1, alu_data2);
   assign alu_zero = (alu_data == '0);

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic reset_model();
      prio_m     = 0;
      next_acc   = 0;
      busy_until = -1;
      last_op    = '{ctrl: 3'b000, a: '0, b: '0};
      sb.delete();
      reqq[0].delete();
      reqq[1].delete();
      pres[0] = 1'b0;
      pres[1] = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_data"},  rsp_data,  0);
      check({tag, "_rsp_zero"},  rsp_zero,  0);
      check({tag, "_illegal"},   illegal,   0);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_alu_d1"},    alu_data1, 0);
      check({tag, "_alu_d2"},    alu_data2, 0);
      check({tag, "_alu_ctrl"},  alu_ctrl,  0);
   endtask

   function automatic op_t rand_op();
      op_t o;
      o.ctrl = 3'($urandom_range(0, 7));
      o.a    = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : $urandom;
      o.b    = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
      return o;
   endfunction

   // One clock of stimulus plus prediction of arbitration, busy and ALU operand registers.
   task automatic cycle_step(input bit allow_drop, output bit granted);
      bit   window, any, exp_r0, exp_r1;
      int   g, hold;
      exp_t e;
      op_t  op;
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
         if (pres[n] && allow_drop && $urandom_range(0, 5) == 0) begin
            pres[n] = 1'b0;
            reqq[n].push_front(cur[n]);
         end else if (!pres[n] && reqq[n].size() > 0) begin
            cur[n]  = reqq[n].pop_front();
            pres[n] = 1'b1;
         end
      end
      r0_valid = pres[0];
      r0_data1 = pres[0] ? cur[0].a    : $urandom;
      r0_data2 = pres[0] ? cur[0].b    : $urandom;
      r0_ctrl  = pres[0] ? cur[0].ctrl : 3'($urandom);
      r1_valid = pres[1];
      r1_data1 = pres[1] ? cur[1].a    : $urandom;
      r1_data2 = pres[1] ? cur[1].b    : $urandom;
      r1_ctrl  = pres[1] ? cur[1].ctrl : 3'($urandom);

      @(negedge clk);
      window = (cyc >= next_acc);
      any    = pres[0] || pres[1];
      g      = (pres[0] && pres[1]) ? prio_m : (pres[1] ? 1 : 0);
      exp_r0 = window && any && (g == 0);
      exp_r1 = window && any && (g == 1);
      check("r0_ready", r0_ready, exp_r0);
      check("r1_ready", r1_ready, exp_r1);
      check("busy", busy, (cyc <= busy_until));
      check("alu_data1", alu_data1, last_op.a);
      check("alu_data2", alu_data2, last_op.b);
      check("alu_ctrl",  alu_ctrl,  last_op.ctrl);

      granted = window && any;
      if (granted) begin
         op    = cur[g];
         hold  = (op.ctrl == 3'b100) ? MUL_LAT : 1;
         e.cyc = cyc + hold + 1;
         e.vld = (g == 1) ? 2'b10 : 2'b01;
         if (is_legal(op.ctrl)) begin
            e.data = alu_fn(op.ctrl, op.a, op.b);
            e.zero = (e.data == '0);
            e.ill  = 1'b0;
         end else begin
            e.data = '0;
            e.zero = 1'b1;
            e.ill  = 1'b1;
         end
         sb.push_back(e);
         next_acc   = cyc + hold;
         busy_until = cyc + hold;
         prio_m     = 1 - g;
         last_op    = op;
         pres[g]    = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      bit g;
      while ((reqq[0].size() > 0 || reqq[1].size() > 0 || pres[0] || pres[1] || sb.size() > 0)
             && n < 300) begin
         cycle_step(1'b0, g);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL drain_timeout: %0d responses still outstanding after %0d cycles", sb.size(), n);
      end
      cycle_step(1'b0, g);
   endtask

   function automatic op_t mk(input logic [2:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      op_t o;
      o.ctrl = c;
      o.a    = a;
      o.b    = b;
      return o;
   endfunction

   // Response monitor, decoupled from stimulus.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing: no response seen, expected at cycle %0d, now %0d", sb[0].cyc, cyc);
            e = sb.pop_front();
         end
         if (rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got rsp_valid %0b with nothing outstanding (cycle %0d)", rsp_valid, cyc);
            end else begin
               e = sb.pop_front();
               check("rsp_cycle",   cyc,       e.cyc);
               check("rsp_valid",   rsp_valid, e.vld);
               check("rsp_data",    rsp_data,  e.data);
               check("rsp_zero",    rsp_zero,  e.zero);
               check("rsp_illegal", illegal,   e.ill);
            end
         end else begin
            check("illegal_idle", illegal, 1'b0);
         end
      end
   end

   initial begin
      bit g;
      int n;
      rst = 1'b1;
      r0_valid = 1'b0; r0_data1 = '0; r0_data2 = '0; r0_ctrl = '0;
      r1_valid = 1'b0; r1_data1 = '0; r1_data2 = '0; r1_ctrl = '0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      check("por_r0_ready", r0_ready, 0);
      check("por_r1_ready", r1_ready, 0);
      rst = 1'b0;

      // Simultaneous requests right after reset: r0 first, then r1.
      reqq[0].push_back(mk(3'b110, 3, 3));
      reqq[1].push_back(mk(3'b001, 0, 0));
      drain();

      // Lone add 5+7.
      reqq[0].push_back(mk(3'b010, 5, 7));
      drain();

      // r1 multiply occupies the ALU while r0 waits.
      reqq[1].push_back(mk(3'b100, 6, 7));
      cycle_step(1'b0, g);
      reqq[0].push_back(mk(3'b000, 32'hf0, 32'h0f));
      drain();

      // Back-to-back adds from r0.
      for (int i = 0; i < 4; i++) reqq[0].push_back(mk(3'b010, WIDTH'(i * 11), WIDTH'(i + 100)));
      drain();

      // Illegal control code.
      reqq[0].push_back(mk(3'b111, 32'h1234, 32'h5678));
      drain();

      // Random traffic with occasional valid drops.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) reqq[0].push_back(rand_op());
         if ($urandom_range(0, 2) == 0) reqq[1].push_back(rand_op());
         cycle_step(1'b1, g);
      end
      drain();

      // Reset while a multiply is in flight.
      reqq[0].push_back(mk(3'b100, 9, 9));
      n = 0;
      g = 1'b0;
      while (!g && n < 20) begin
         cycle_step(1'b0, g);
         n++;
      end
      check("mid_rst_mul_accepted", g, 1'b1);
      cycle_step(1'b0, g);
      cycle_step(1'b0, g);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) cycle_step(1'b0, g);
      reqq[0].push_back(mk(3'b010, 20, 22));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
